// File: rtl/booth_mul.sv
// ---------------------------------------------------------------------------
// booth_mul -- sequential signed radix-4 Booth multiplier
//
// Multiplies two WIDTH-bit two's-complement operands into a 2*WIDTH-bit
// product using WIDTH/2 add/shift iterations. The product is driven onto
// the shared tri-state output buses for exactly one cycle (DONE), with fin
// strobing high in that same cycle.
//
// Optional feature: define MUL_OVF_EN to add the ovf output. ovf flags a
// product that does not fit in WIDTH signed bits. It is only valid in DONE.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_b  in   synchronous active-low reset
//   bgn    in   start request, sampled only in IDLE
//   ibusA  in   multiplicand (signed), captured on the start edge
//   ibusB  in   multiplier (signed), captured on the start edge
//   obusA  out  product high half in DONE, else high-Z
//   obusB  out  product low half in DONE, else high-Z
//   busy   out  high in LOAD, ADD and SHIFT
//   fin    out  one-cycle done strobe (DONE)
//   ovf    out  (MUL_OVF_EN only) product overflows WIDTH signed bits
// ---------------------------------------------------------------------------
module booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bgn,
  input  logic [WIDTH-1:0] ibusA,
  input  logic [WIDTH-1:0] ibusB,
  output logic [WIDTH-1:0] obusA,
  output logic [WIDTH-1:0] obusB,
  output logic             busy,
`ifdef MUL_OVF_EN
  output logic             fin,
  output logic             ovf
`else
  output logic             fin
`endif
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH / 2 - 1);

  // One-hot encoding: busy and fin come straight from state flops.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_LOAD  = 5'b00010,
    S_ADD   = 5'b00100,
    S_SHIFT = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_m;
  logic [AW-1:0]    r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;

  logic [AW-1:0]    w_m1;
  logic [AW-1:0]    w_m2;
  logic [AW-1:0]    w_addend;
  logic             w_cin;
  logic [AW-1:0]    w_sum;
  logic             w_drive;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bgn) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_ADD;
      S_ADD:   w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = (r_cnt == LAST_ITER) ? S_DONE : S_ADD;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    busy    = 1'b0;
    fin     = 1'b0;
    w_drive = 1'b0;
    case (r_state)
      S_LOAD, S_ADD, S_SHIFT: busy = 1'b1;
      S_DONE: begin
        fin     = 1'b1;
        w_drive = 1'b1;
      end
      default: ;
    endcase
  end

  assign obusA = w_drive ? r_a[WIDTH-1:0] : {WIDTH{1'bz}};
  assign obusB = w_drive ? r_q            : {WIDTH{1'bz}};

`ifdef MUL_OVF_EN
  // The product fits in WIDTH signed bits only if the high half is pure
  // sign extension of the low half.
  assign ovf = w_drive && (r_a[WIDTH-1:0] != {WIDTH{r_q[WIDTH-1]}});
`endif

  // ---------------- Booth recoding adder ----------------
  // Two guard bits on the accumulator keep +/-2M of the most negative
  // operand representable, so no internal overflow can occur.
  assign w_m1 = {{2{r_m[WIDTH-1]}}, r_m};
  assign w_m2 = {w_m1[AW-2:0], 1'b0};

  always_comb begin
    w_addend = '0;
    w_cin    = 1'b0;
    case ({r_q[1:0], r_q1})
      3'b001, 3'b010: w_addend = w_m1;
      3'b011:         w_addend = w_m2;
      3'b100: begin
        w_addend = ~w_m2;
        w_cin    = 1'b1;
      end
      3'b101, 3'b110: begin
        w_addend = ~w_m1;
        w_cin    = 1'b1;
      end
      default: w_addend = '0;
    endcase
  end

  // Carry-out is intentionally dropped: the sum wraps at AW bits.
  assign w_sum = r_a + w_addend + {{(AW-1){1'b0}}, w_cin};

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bgn) begin
            r_m <= ibusA;
            r_q <= ibusB;
          end
        end
        S_LOAD: begin
          r_a   <= '0;
          r_q1  <= 1'b0;
          r_cnt <= '0;
        end
        S_ADD: begin
          r_a <= w_sum;
        end
        S_SHIFT: begin
          // 2-bit arithmetic right shift of the combined {A, Q, q_1}.
          r_q1  <= r_q[1];
          r_q   <= {r_a[1:0], r_q[WIDTH-1:2]};
          r_a   <= {{2{r_a[AW-1]}}, r_a[AW-1:2]};
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_mul.md
Name: booth_mul

Overview:
- Sequential signed multiplier, radix-4 Booth; the multiply counterpart of the team's sequential divider in the structural ALU.
- Takes two WIDTH-bit two's-complement operands from the ALU input buses.
- Produces a 2*WIDTH-bit product over WIDTH/2 add/shift iterations.
- Drives the product onto the shared tri-state output buses for one cycle, with a done strobe.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  reset; synchronous, active-low
- bgn  input  1  start request, sampled only in IDLE
- ibusA  input  WIDTH  multiplicand (signed), captured on the start edge
- ibusB  input  WIDTH  multiplier (signed), captured on the start edge
- obusA  output  WIDTH  product high half in DONE, else all Z
- obusB  output  WIDTH  product low half in DONE, else all Z
- busy  output  1  high in LOAD, ADD and SHIFT states
- fin  output  1  one-cycle done strobe, high only in DONE
- ovf  output  1  present only with MUL_OVF_EN (see Optional Feature)

Behaviour:
- Reset: clk edge with rst_b=0 forces state IDLE and clears M, A, Q, q_1 and the iteration counter. busy=0, fin=0, obusA/obusB=Z. Applies in any state, aborting any multiply in progress.
- Registers:
  - M (WIDTH), sign-extended to WIDTH+2 for the adder.
  - A accumulator (WIDTH+2).
  - Q multiplier (WIDTH).
  - q_1 (1).
  - cnt, $clog2(WIDTH/2)+1 bits.
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE: edge with bgn=1 latches ibusA into M and ibusB into Q, then goes to LOAD. bgn=0 stays in IDLE.
- LOAD: clears A, q_1 and cnt; goes to ADD.
- ADD: Booth decode of {Q[1],Q[0],q_1}:
  - 000 or 111: A unchanged.
  - 001 or 010: A+=M.
  - 011: A+=2M.
  - 100: A-=2M.
  - 101 or 110: A-=M.
  - Subtract is done as A + ~X + 1 (invert plus carry-in), WIDTH+2-bit wrap; the adder carry-out is discarded.
  - Goes to SHIFT.
- SHIFT: 2-bit arithmetic right shift of {A,Q,q_1}:
  - q_1<=Q[1].
  - Q<={A[1:0],Q[WIDTH-1:2]}.
  - A<={A[W+1],A[W+1],A[W+1:2]}.
  - cnt<=cnt+1.
  - If cnt==WIDTH/2-1 before the increment, go to DONE; else go to ADD.
- DONE: fin=1; obusA=A[WIDTH-1:0], obusB=Q. Goes to IDLE on the next edge; busy=0 in this state.
- Latency: with the start edge as edge 0, fin is high in the cycle after edge WIDTH+1 (cycle after edge 33 for WIDTH=32). Latency is fixed and independent of operand values.
- bgn while not in IDLE is ignored, including during DONE. A new multiply can start on the edge that returns DONE to IDLE only if bgn is sampled in IDLE, i.e. one cycle later.
- ibusA/ibusB are don't-care after the start edge.
- Operands are full-range signed. -2^(W-1) * -2^(W-1) must give the exact product 2^(2W-2); the WIDTH+2 accumulator guarantees no internal overflow.
- fin and busy are registered state decodes, so they are glitch-free.

Optional Feature:
- Macro: MUL_OVF_EN.
- Defined:
  - Port ovf exists.
  - In DONE, ovf=1 iff the product does not fit in WIDTH signed bits, i.e. A[WIDTH-1:0] != {WIDTH{Q[WIDTH-1]}}.
  - ovf=0 in every other state and after reset.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- 3 x 5, WIDTH=32 -> fin high exactly one cycle, 33 edges after the start edge; obusA=0x00000000, obusB=0x0000000F; Z on both buses in all other cycles.
- -7 (0xFFFFFFF9) x 6 -> obusA=0xFFFFFFFF, obusB=0xFFFFFFD6. Also -1 x -1 -> obusA=0, obusB=1.
- 0x80000000 x 0x80000000 -> obusA=0x40000000, obusB=0x00000000. With MUL_OVF_EN: ovf=1.
- 0x00010000 x 0x00010000 -> obusA=0x00000001, obusB=0. With MUL_OVF_EN: ovf=1. A 3 x 5 case gives ovf=0.
- bgn held high for 40 cycles with changing ibusA/ibusB -> result uses only the first-sampled operands; the second start begins only after IDLE is re-entered.
- rst_b=0 for one edge mid-operation (in ADD, iteration 5), then a new 2 x 2 -> busy=0, fin=0, buses Z after reset; then obusB=4, obusA=0; no stale fin.
